// File: rtl/fric_initiator.sv
// FRIC byte-lane initiator: serialises one host request onto fric_out and
// collects and checks the matching reply on fric_in, one transaction at a time.
module fric_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  fric_out,
  input  logic [7:0]  fric_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [3:0]  req_port,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  typedef enum logic [3:0] {
    IDLE, TX_HDR, TX_ADDR, TX_DLO, TX_DHI, WAIT, RX_ADDR, RX_DLO, RX_DHI, DONE
  } state_t;

  state_t      state, state_d;
  logic        lat_rnw;
  logic [3:0]  lat_port;
  logic [7:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic [1:0]  err_q, err_d;
  logic [7:0]  dlo_q;
  logic [7:0]  out_d;
  logic [15:0] done_rdata;
  logic [TO_W-1:0] cnt;
  logic [7:0]  exp_hdr;

  assign req_ready = rst & (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign exp_hdr   = {(lat_rnw ? 4'h4 : 4'h2), lat_port};

  // out_d is the byte for the state being entered, so fric_out is registered
  // yet aligned with that state.
  always_comb begin
    state_d    = state;
    out_d      = 8'h00;
    err_d      = err_q;
    done_rdata = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = TX_HDR;
          out_d   = {(req_rnw ? 4'h3 : 4'h1), req_port};
          err_d   = 2'd0;
        end
      end
      TX_HDR: begin
        state_d = TX_ADDR;
        out_d   = lat_addr;
      end
      TX_ADDR: begin
        if (lat_rnw) begin
          state_d = WAIT;
        end else begin
          state_d = TX_DLO;
          out_d   = lat_wdata[7:0];
        end
      end
      TX_DLO: begin
        state_d = TX_DHI;
        out_d   = lat_wdata[15:8];
      end
      TX_DHI: state_d = WAIT;
      WAIT: begin
        if (fric_in == 8'h00) begin
          if (cnt == TO_W'(TIMEOUT - 1)) begin
            state_d = DONE;
            err_d   = 2'd1;
          end
        end else if (fric_in == exp_hdr) begin
          state_d = RX_ADDR;
        end else begin
          state_d = DONE;
          err_d   = 2'd2;
        end
      end
      RX_ADDR: begin
        if (fric_in != lat_addr) err_d = 2'd2;
        state_d = lat_rnw ? RX_DLO : DONE;
      end
      RX_DLO: state_d = RX_DHI;
      RX_DHI: begin
        state_d = DONE;
        if (err_q == 2'd0) done_rdata = {fric_in, dlo_q};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fric_out  <= 8'h00;
      lat_rnw   <= 1'b0;
      lat_port  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= '0;
      dlo_q     <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      state    <= state_d;
      fric_out <= out_d;
      err_q    <= err_d;
      if (state == IDLE && req_valid) begin
        lat_rnw   <= req_rnw;
        lat_port  <= req_port;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state == RX_DLO) dlo_q <= fric_in;
      if (state != WAIT)
        cnt <= '0;
      else if (fric_in == 8'h00)
        cnt <= cnt + TO_W'(1);
      if (state_d == DONE) begin
        rsp_err   <= err_d;
        rsp_rdata <= done_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fric_initiator.sv
// Self-checking bench for fric_initiator: directed scenarios plus randomized
// transactions, each checked against a packet-level reference model.
module tb_fric_initiator;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fric_out;
  logic [7:0]  fric_in = 8'h00;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rnw = 1'b0;
  logic [3:0]  req_port = '0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int tests = 0;
  int fails = 0;
  logic [7:0]  rq[$];
  logic [15:0] last_rdata;
  logic [1:0]  last_err;

  fric_initiator #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .fric_out(fric_out), .fric_in(fric_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_port(req_port), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qb(input int i);
    return (i < rq.size()) ? rq[i] : 8'h00;
  endfunction

  task automatic set_reply(input logic [63:0] bytes, input int n);
    rq.delete();
    for (int i = 0; i < n; i++) rq.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  // Reference: scan the reply stream as a packet, return how many reply bytes
  // the initiator consumes and the response it must give.
  task automatic model(input logic rnw, input logic [3:0] port, input logic [7:0] addr,
                       output int consumed, output logic [1:0] err, output logic [15:0] rdata);
    int idle = 0;
    logic [7:0] b;
    consumed = 0; err = 2'd0; rdata = 16'h0000;
    for (int j = 0; j <= TIMEOUT + rq.size(); j++) begin
      b = qb(j);
      if (b == 8'h00) begin
        idle++;
        if (idle == TIMEOUT) begin err = 2'd1; consumed = j + 1; return; end
      end else begin
        if (b != {(rnw ? 4'h4 : 4'h2), port}) begin err = 2'd2; consumed = j + 1; return; end
        err = (qb(j + 1) == addr) ? 2'd0 : 2'd2;
        consumed = j + (rnw ? 4 : 2);
        if (rnw && err == 2'd0) rdata = {qb(j + 3), qb(j + 2)};
        return;
      end
    end
  endtask

  // Called at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic run_txn(input logic rnw, input logic [3:0] port, input logic [7:0] addr,
                         input logic [15:0] wdata, input string tag);
    logic [7:0]  rb[4];
    int          nreq, consumed, exp_c, last, first, nvalid;
    logic [1:0]  e_err, o_err;
    logic [15:0] e_rd, o_rd;
    rb[0] = {(rnw ? 4'h3 : 4'h1), port};
    rb[1] = addr;
    rb[2] = wdata[7:0];
    rb[3] = wdata[15:8];
    nreq  = rnw ? 2 : 4;
    model(rnw, port, addr, consumed, e_err, e_rd);
    exp_c = nreq + consumed;
    last  = (exp_c + 1 > nreq + rq.size()) ? exp_c + 1 : nreq + rq.size();
    req_rnw = rnw; req_port = port; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    first = -1; nvalid = 0; o_rd = '0; o_err = '0;
    for (int c = 0; c <= last; c++) begin
      chk($sformatf("%s.out%0d", tag, c), 32'(fric_out), (c < nreq) ? 32'(rb[c]) : 32'd0);
      if (rsp_valid === 1'b1) begin
        nvalid++;
        if (first < 0) begin first = c; o_rd = rsp_rdata; o_err = rsp_err; end
      end
      if (c == last) break;
      fric_in = (c >= nreq) ? qb(c - nreq) : 8'h00;
      if (c <= exp_c) begin
        req_valid = 1'($urandom); req_rnw = 1'($urandom); req_port = 4'($urandom);
        req_addr = 8'($urandom); req_wdata = 16'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    fric_in = 8'h00; req_valid = 1'b0;
    chk({tag, ".rsp_cycle"}, 32'(first), 32'(exp_c));
    chk({tag, ".rsp_count"}, 32'(nvalid), 32'd1);
    chk({tag, ".rdata"}, 32'(o_rd), 32'(e_rd));
    chk({tag, ".err"}, 32'(o_err), 32'(e_err));
    chk({tag, ".hold"}, {14'd0, rsp_err, rsp_rdata}, {14'd0, e_err, e_rd});
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    last_rdata = o_rd; last_err = o_err;
  endtask

  function automatic logic [7:0] rbyte();
    return ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
  endfunction

  initial begin
    logic        rnw;
    logic [3:0]  port;
    logic [7:0]  addr, eh, h;
    logic [15:0] wdata;
    int          gap;

    #3;
    chk("rst.fric_out", 32'(fric_out), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp", {14'd0, rsp_err, rsp_rdata}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("rel.req_ready", 32'(req_ready), 32'd1);

    set_reply(64'h00_00_23_10, 4);
    run_txn(1'b0, 4'd3, 8'h10, 16'hBEEF, "wr_beef");
    chk("wr_beef.const", {14'd0, last_err, last_rdata}, 32'h0000_0000);

    set_reply(64'h00_45_42_00_7A, 5);
    run_txn(1'b1, 4'd5, 8'h42, 16'h0000, "rd_7a00");
    chk("rd_7a00.const", {14'd0, last_err, last_rdata}, 32'h0000_7A00);

    rq.delete();
    run_txn(1'b1, 4'd1, 8'h55, 16'h0000, "rd_tmo");
    chk("rd_tmo.const", {14'd0, last_err, last_rdata}, 32'h0001_0000);

    set_reply(64'h46_42_11_22, 4);
    run_txn(1'b1, 4'd5, 8'h42, 16'h0000, "rd_badhdr");
    chk("rd_badhdr.const", {14'd0, last_err, last_rdata}, 32'h0002_0000);
    set_reply(64'h00_22_20, 3);
    run_txn(1'b0, 4'd2, 8'h20, 16'h1111, "wr_after_bad");
    chk("wr_after_bad.const", {14'd0, last_err, last_rdata}, 32'h0000_0000);

    set_reply(64'h45_43_34_12, 4);
    run_txn(1'b1, 4'd5, 8'h42, 16'h0000, "rd_badaddr");
    chk("rd_badaddr.const", {14'd0, last_err, last_rdata}, 32'h0002_0000);

    // Reset in the middle of a write request.
    req_rnw = 1'b0; req_port = 4'd7; req_addr = 8'h33; req_wdata = 16'hA55A; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid.hdr", 32'(fric_out), 32'h17);
    @(posedge clk); #1;
    chk("mid.addr", 32'(fric_out), 32'h33);
    @(posedge clk); #1;
    chk("mid.dlo", 32'(fric_out), 32'h5A);
    rst = 1'b0; #1;
    chk("mid.rst_out", 32'(fric_out), 32'd0);
    chk("mid.rst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid.rst_valid%0d", i), 32'(rsp_valid), 32'd0);
    end
    rst = 1'b1; #1;
    chk("mid.rel_ready", 32'(req_ready), 32'd1);
    set_reply(64'h00_27_60, 3);
    run_txn(1'b0, 4'd7, 8'h60, 16'h0102, "b2b_a");
    set_reply(64'h27_61, 2);
    run_txn(1'b0, 4'd7, 8'h61, 16'h0304, "b2b_b");

    for (int k = 0; k < 40; k++) begin
      rnw   = 1'($urandom);
      port  = 4'($urandom);
      addr  = 8'($urandom);
      wdata = 16'($urandom);
      eh    = {(rnw ? 4'h4 : 4'h2), port};
      gap   = $urandom_range(0, TIMEOUT - 1);
      rq.delete();
      for (int i = 0; i < gap; i++) rq.push_back(8'h00);
      case ($urandom_range(0, 3))
        0: begin
          rq.push_back(eh); rq.push_back(addr);
          if (rnw) begin rq.push_back(rbyte()); rq.push_back(rbyte()); end
        end
        1: ;
        2: begin
          do h = 8'($urandom_range(1, 255)); while (h == eh);
          rq.push_back(h);
          for (int i = 0; i < $urandom_range(0, 3); i++) rq.push_back(rbyte());
        end
        default: begin
          rq.push_back(eh); rq.push_back(addr ^ 8'($urandom_range(1, 255)));
          if (rnw) begin rq.push_back(rbyte()); rq.push_back(rbyte()); end
        end
      endcase
      run_txn(rnw, port, addr, wdata, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
